// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority over a FIFO of
// multdiv results. It flags RAW hazards to decode. Define WB_BYPASS_EN to forward the in-flight write.
module regfile_wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       ctrl_reset,
    input  logic                       pipe_we,
    input  logic [4:0]                 pipe_rd,
    input  logic [31:0]                pipe_data,
    input  logic                       md_valid,
    input  logic [4:0]                 md_rd,
    input  logic [31:0]                md_data,
    output logic                       md_ready,
    output logic                       rf_we,
    output logic [4:0]                 rf_wreg,
    output logic [31:0]                rf_wdata,
    input  logic [4:0]                 rd_a,
    input  logic [4:0]                 rd_b,
    input  logic [31:0]                rf_data_a,
    input  logic [31:0]                rf_data_b,
    output logic [31:0]                op_a,
    output logic [31:0]                op_b,
    output logic                       stall_hazard,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [DEPTH-1:0] ent_valid_q, ent_valid_d;
    logic [4:0]       ent_rd_q   [DEPTH];
    logic [31:0]      ent_data_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_wreg_q, rf_wreg_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;

    logic pipe_issue_s, push_s, pop_s, md_ready_s;
    logic hz_a_s, hz_b_s;

    assign md_ready_s = (count_q < CNT_FULL);

    // Issue selection, WAW kill and FIFO bookkeeping for the next edge
    always_comb begin
        pipe_issue_s = pipe_we && (pipe_rd != 5'd0);
        push_s       = md_valid && md_ready_s && (md_rd != 5'd0);
        pop_s        = !pipe_issue_s && (count_q != {CW{1'b0}});
        ent_valid_d  = ent_valid_q;
        rf_we_d      = 1'b0;
        rf_wreg_d    = 5'd0;
        rf_wdata_d   = 32'd0;
        rptr_d       = rptr_q;
        wptr_d       = wptr_q;
        count_d      = count_q;

        if (pipe_issue_s) begin
            rf_we_d    = 1'b1;
            rf_wreg_d  = pipe_rd;
            rf_wdata_d = pipe_data;
            // A newer pipeline write makes any queued result for that register stale.
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_rd_q[i] == pipe_rd) begin
                    ent_valid_d[i] = 1'b0;
                end else begin
                    ent_valid_d[i] = ent_valid_d[i];
                end
            end
        end else if (pop_s) begin
            rf_we_d             = ent_valid_q[rptr_q];
            rf_wreg_d           = ent_rd_q[rptr_q];
            rf_wdata_d          = ent_data_q[rptr_q];
            ent_valid_d[rptr_q] = 1'b0;
            rptr_d              = rptr_q + PTR_ONE;
        end else begin
            rf_we_d = 1'b0;
        end

        if (push_s) begin
            ent_valid_d[wptr_q] = !(pipe_issue_s && (md_rd == pipe_rd));
            wptr_d              = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage, pointers and registered write port
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            ent_valid_q <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                ent_rd_q[i]   <= 5'd0;
                ent_data_q[i] <= 32'd0;
            end
            wptr_q     <= {AW{1'b0}};
            rptr_q     <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            rf_we_q    <= 1'b0;
            rf_wreg_q  <= 5'd0;
            rf_wdata_q <= 32'd0;
        end else begin
            ent_valid_q <= ent_valid_d;
            if (push_s) begin
                ent_rd_q[wptr_q]   <= md_rd;
                ent_data_q[wptr_q] <= md_data;
            end
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_wreg_q  <= rf_wreg_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Read-after-write hazard against queued, arriving and (without bypass) in-flight writes
    always_comb begin
        hz_a_s = push_s && (md_rd == rd_a);
        hz_b_s = push_s && (md_rd == rd_b);
        for (int i = 0; i < DEPTH; i++) begin
            hz_a_s = hz_a_s | (ent_valid_q[i] && (ent_rd_q[i] == rd_a));
            hz_b_s = hz_b_s | (ent_valid_q[i] && (ent_rd_q[i] == rd_b));
        end
`ifndef WB_BYPASS_EN
        hz_a_s = hz_a_s | (rf_we_q && (rf_wreg_q == rd_a));
        hz_b_s = hz_b_s | (rf_we_q && (rf_wreg_q == rd_b));
`endif
        hz_a_s = hz_a_s && (rd_a != 5'd0);
        hz_b_s = hz_b_s && (rd_b != 5'd0);
    end

`ifdef WB_BYPASS_EN
    assign op_a = (rf_we_q && (rf_wreg_q == rd_a) && (rd_a != 5'd0)) ? rf_wdata_q : rf_data_a;
    assign op_b = (rf_we_q && (rf_wreg_q == rd_b) && (rd_b != 5'd0)) ? rf_wdata_q : rf_data_b;
`else
    assign op_a = rf_data_a;
    assign op_b = rf_data_b;
`endif

    assign stall_hazard = hz_a_s || hz_b_s;
    assign md_ready     = md_ready_s;
    assign rf_we        = rf_we_q;
    assign rf_wreg      = rf_wreg_q;
    assign rf_wdata     = rf_wdata_q;
    assign fifo_count   = count_q;

endmodule
